// File: rtl/func_unit_r_if.sv
// Reservation-station and common-data-bus signal bundle for func_unit_r.
// The unit sits on the slave side; the station/arbiter environment is the master.
interface func_unit_r_if;
    logic        Busy;
    logic        Clear_counter;
    logic [2:0]  Ufop;
    logic [15:0] Vj_reg;
    logic [15:0] Vk_reg;
    logic [2:0]  Qj_reg;
    logic [2:0]  Qk_reg;
    logic [2:0]  R_target;
    logic        Cdb_valid;
    logic [2:0]  Cdb_tag;
    logic [15:0] Cdb_data;
    logic        Cdb_grant;
    logic        Cdb_req;
    logic [2:0]  Cdb_out_tag;
    logic [15:0] Cdb_out_data;
    logic [2:0]  Cdb_out_rd;
    logic        Ready;
    logic        Done;
    logic        Finished;

    modport slave (
        input  Busy, Clear_counter, Ufop, Vj_reg, Vk_reg, Qj_reg, Qk_reg, R_target,
        input  Cdb_valid, Cdb_tag, Cdb_data, Cdb_grant,
        output Cdb_req, Cdb_out_tag, Cdb_out_data, Cdb_out_rd, Ready, Done, Finished
    );

    modport master (
        output Busy, Clear_counter, Ufop, Vj_reg, Vk_reg, Qj_reg, Qk_reg, R_target,
        output Cdb_valid, Cdb_tag, Cdb_data, Cdb_grant,
        input  Cdb_req, Cdb_out_tag, Cdb_out_data, Cdb_out_rd, Ready, Done, Finished
    );
endinterface

// File: rtl/func_unit_r.sv
// Tomasulo-style functional unit: captures an instruction from its reservation
// station, snoops the CDB for missing operands, executes, and broadcasts the result.
module func_unit_r #(
    parameter logic [2:0] TAG     = 3'b001,
    parameter int         LAT_ALU = 1,
    parameter int         LAT_MUL = 3
) (
    input logic          Clock,
    input logic          Reset,
    func_unit_r_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_OPS,
        S_EXEC,
        S_BCAST,
        S_FIN
    } state_e;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_SLT = 3'b100,
        OP_SLL = 3'b101,
        OP_SRL = 3'b110,
        OP_MUL = 3'b111
    } op_e;

    localparam logic [7:0] ALU_LOAD = 8'(LAT_ALU - 1);
    localparam logic [7:0] MUL_LOAD = 8'(LAT_MUL - 1);

    state_e      state;
    logic [7:0]  cnt;
    op_e         op;
    logic [15:0] vj;
    logic [15:0] vk;
    logic [2:0]  qj;
    logic [2:0]  qk;
    logic [2:0]  rd;
    logic [15:0] result;
    logic        done;
    logic        req;
    logic        finished;
    logic [2:0]  out_tag;
    logic [15:0] out_data;
    logic [2:0]  out_rd;

    logic        ready;
    logic        cap_j;
    logic        cap_k;
    logic        snoop_j;
    logic        snoop_k;
    logic [15:0] alu_out;

    assign ready = (qj == 3'b000) && (qk == 3'b000);

    // Forwarding straight from the bus at capture time, and while waiting on local tags.
    assign cap_j   = bus.Cdb_valid && (bus.Qj_reg != 3'b000) && (bus.Cdb_tag == bus.Qj_reg);
    assign cap_k   = bus.Cdb_valid && (bus.Qk_reg != 3'b000) && (bus.Cdb_tag == bus.Qk_reg);
    assign snoop_j = bus.Cdb_valid && (qj != 3'b000) && (bus.Cdb_tag == qj);
    assign snoop_k = bus.Cdb_valid && (qk != 3'b000) && (bus.Cdb_tag == qk);

    always_comb begin
        // NOTE: default assignment first, so no opcode path leaves alu_out unassigned and infers a latch.
        alu_out = 16'h0000;
        case (op)
            OP_ADD:  alu_out = vj + vk;
            OP_SUB:  alu_out = vj - vk;
            OP_AND:  alu_out = vj & vk;
            OP_OR:   alu_out = vj | vk;
            OP_SLT:  alu_out = {15'd0, $signed(vj) < $signed(vk)};
            OP_SLL:  alu_out = vj << vk[3:0];
            OP_SRL:  alu_out = vj >> vk[3:0];
            OP_MUL:  alu_out = vj * vk;
            default: alu_out = 16'h0000;
        endcase
    end

    always_ff @(posedge Clock) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (Reset) begin
            state    <= S_IDLE;
            cnt      <= 8'd0;
            op       <= OP_ADD;
            vj       <= 16'hFFF0;
            vk       <= 16'hFFF0;
            qj       <= 3'b000;
            qk       <= 3'b000;
            rd       <= 3'b000;
            result   <= 16'h0000;
            done     <= 1'b0;
            req      <= 1'b0;
            finished <= 1'b0;
            out_tag  <= 3'b000;
            out_data <= 16'h0000;
            out_rd   <= 3'b000;
        end else begin
            finished <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.Busy && !bus.Clear_counter) begin
                        op    <= op_e'(bus.Ufop);
                        rd    <= bus.R_target;
                        vj    <= cap_j ? bus.Cdb_data : bus.Vj_reg;
                        qj    <= cap_j ? 3'b000 : bus.Qj_reg;
                        vk    <= cap_k ? bus.Cdb_data : bus.Vk_reg;
                        qk    <= cap_k ? 3'b000 : bus.Qk_reg;
                        state <= S_WAIT_OPS;
                    end
                end
                S_WAIT_OPS: begin
                    if (!bus.Busy) begin
                        state <= S_IDLE;
                    end else begin
                        if (snoop_j) begin
                            vj <= bus.Cdb_data;
                            qj <= 3'b000;
                        end
                        if (snoop_k) begin
                            vk <= bus.Cdb_data;
                            qk <= 3'b000;
                        end
                        if (ready) begin
                            cnt   <= (op == OP_MUL) ? MUL_LOAD : ALU_LOAD;
                            state <= S_EXEC;
                        end
                    end
                end
                S_EXEC: begin
                    if (!bus.Busy) begin
                        state <= S_IDLE;
                    end else if (bus.Clear_counter) begin
                        cnt <= 8'd0;
                    end else if (cnt == 8'd0) begin
                        result   <= alu_out;
                        out_data <= alu_out;
                        out_tag  <= TAG;
                        out_rd   <= rd;
                        done     <= 1'b1;
                        req      <= 1'b1;
                        state    <= S_BCAST;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                S_BCAST: begin
                    // Abort wins over a simultaneous grant: the station withdrew the instruction.
                    if (!bus.Busy || bus.Cdb_grant) begin
                        done     <= 1'b0;
                        req      <= 1'b0;
                        out_tag  <= 3'b000;
                        out_data <= 16'h0000;
                        out_rd   <= 3'b000;
                        finished <= bus.Busy;
                        state    <= bus.Busy ? S_FIN : S_IDLE;
                    end
                end
                S_FIN: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.Ready        = ready;
    assign bus.Done         = done;
    assign bus.Cdb_req      = req;
    assign bus.Finished     = finished;
    assign bus.Cdb_out_tag  = out_tag;
    assign bus.Cdb_out_data = out_data;
    assign bus.Cdb_out_rd   = out_rd;

endmodule

// File: tb/tb_func_unit_r.sv
// Self-checking bench for func_unit_r: directed vector table, hand-written
// abort/reset/clear sequences, and randomized operations against a reference model.
module tb_func_unit_r;

    localparam logic [2:0] TAG     = 3'b001;
    localparam int         LAT_ALU = 1;
    localparam int         LAT_MUL = 3;

    logic clk;
    logic rst;
    int   n_vec = 0;
    int   n_bad = 0;

    func_unit_r_if bus ();

    func_unit_r #(
        .TAG    (TAG),
        .LAT_ALU(LAT_ALU),
        .LAT_MUL(LAT_MUL)
    ) dut (
        .Clock(clk),
        .Reset(rst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  qj;
        logic [2:0]  qk;
        logic [2:0]  rd;
        int          snoop_k;
        logic [15:0] sdata;
        int          gwait;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Reference results from plain integer arithmetic on unsigned 16-bit values.
    function automatic logic [15:0] ref_alu(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        longint ia;
        longint ib;
        longint sa;
        longint sb;
        longint sh;
        ia = longint'(a);
        ib = longint'(b);
        sh = ib % 16;
        sa = (ia >= 32768) ? ia - 65536 : ia;
        sb = (ib >= 32768) ? ib - 65536 : ib;
        case (op)
            3'd0:    return 16'((ia + ib) % 65536);
            3'd1:    return 16'((ia - ib + 65536) % 65536);
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return (sa < sb) ? 16'd1 : 16'd0;
            3'd5:    return 16'((ia * (longint'(1) << sh)) % 65536);
            3'd6:    return 16'(ia / (longint'(1) << sh));
            default: return 16'((ia * ib) % 65536);
        endcase
    endfunction

    // One full instruction: capture, optional snoop k edges after capture, broadcast, grant, finish.
    task automatic run_op(input string name, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                          input logic [2:0] qj, input logic [2:0] qk, input logic [2:0] rd,
                          input int snoop_k, input logic [15:0] sdata, input int gwait, input logic [15:0] exp);
        int         cycles;
        int         exp_cycles;
        int         lat;
        bit         dep;
        bit         early;
        bit         hold_ok;
        logic [2:0] stag;
        dep        = (qj != 3'b000) || (qk != 3'b000);
        stag       = (qj != 3'b000) ? qj : qk;
        lat        = (op == 3'b111) ? LAT_MUL : LAT_ALU;
        // Done becomes visible at the (lat + 2 + snoop delay)-th falling edge after capture.
        exp_cycles = lat + 2 + (dep ? snoop_k : 0);

        @(negedge clk);
        // NOTE: stimulus is driven with blocking assignments on the falling edge, well clear of the sampling edge.
        bus.Busy          = 1'b1;
        bus.Clear_counter = 1'b0;
        bus.Ufop          = op;
        bus.Vj_reg        = a;
        bus.Vk_reg        = b;
        bus.Qj_reg        = qj;
        bus.Qk_reg        = qk;
        bus.R_target      = rd;
        bus.Cdb_grant     = (gwait == 0);
        bus.Cdb_valid     = dep && (snoop_k == 0);
        bus.Cdb_tag       = stag;
        bus.Cdb_data      = sdata;

        cycles = 0;
        early  = 1'b0;
        do begin
            @(negedge clk);
            cycles++;
            if (dep && snoop_k > 0 && cycles == snoop_k)
                check({name, "_not_ready"}, 32'(bus.Ready), 32'd0);
            if (cycles == (dep ? snoop_k : 0) + 1)
                check({name, "_ready"}, 32'(bus.Ready), 32'd1);
            if (!bus.Done && bus.Cdb_req) early = 1'b1;
            bus.Cdb_valid = dep && (cycles == snoop_k);
        end while (!bus.Done && cycles < 100);
        bus.Cdb_valid = 1'b0;

        check({name, "_latency"}, 32'(cycles), 32'(exp_cycles));
        check({name, "_data"}, 32'(bus.Cdb_out_data), 32'(exp));
        check({name, "_tag"}, 32'(bus.Cdb_out_tag), 32'(TAG));
        check({name, "_rd"}, 32'(bus.Cdb_out_rd), 32'(rd));
        check({name, "_req"}, 32'(bus.Cdb_req), 32'd1);
        check({name, "_early_req"}, 32'(early), 32'd0);

        for (int i = 1; i < gwait; i++) begin
            @(negedge clk);
            hold_ok = bus.Done && bus.Cdb_req && !bus.Finished && (bus.Cdb_out_data == exp) &&
                      (bus.Cdb_out_tag == TAG) && (bus.Cdb_out_rd == rd);
            check({name, "_hold"}, 32'(hold_ok), 32'd1);
        end
        bus.Cdb_grant = 1'b1;

        @(negedge clk);
        check({name, "_finished"}, 32'(bus.Finished), 32'd1);
        check({name, "_fin_quiet"},
              32'({bus.Done, bus.Cdb_req, bus.Cdb_out_tag, bus.Cdb_out_data, bus.Cdb_out_rd}), 32'd0);
        bus.Busy      = 1'b0;
        bus.Cdb_grant = 1'b0;
        @(negedge clk);
        check({name, "_finished_pulse"}, 32'(bus.Finished), 32'd0);
    endtask

    initial begin
        int          cycles;
        bit          bad;
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] sdata;
        logic [2:0]  stag;
        logic [2:0]  qj;
        logic [2:0]  qk;
        int          dep_sel;

        //            op      a         b         qj    qk    rd    k  sdata     gw exp
        tbl[0]  = '{3'd0, 16'd5,    16'd7,    3'd0, 3'd0, 3'd3, 0, 16'd0,    0, 16'd12};
        tbl[1]  = '{3'd1, 16'hDEAD, 16'd8,    3'd2, 3'd0, 3'd5, 2, 16'd20,   0, 16'd12};
        tbl[2]  = '{3'd7, 16'd300,  16'd300,  3'd0, 3'd0, 3'd1, 0, 16'd0,    0, 16'h5F90};
        tbl[3]  = '{3'd2, 16'hF0F0, 16'h3C3C, 3'd0, 3'd0, 3'd6, 0, 16'd0,    5, 16'h3030};
        tbl[4]  = '{3'd3, 16'h1200, 16'h0034, 3'd0, 3'd0, 3'd7, 0, 16'd0,    1, 16'h1234};
        tbl[5]  = '{3'd4, 16'hFFFF, 16'h0001, 3'd0, 3'd0, 3'd2, 0, 16'd0,    0, 16'h0001};
        tbl[6]  = '{3'd4, 16'h0001, 16'hFFFF, 3'd0, 3'd0, 3'd2, 0, 16'd0,    0, 16'h0000};
        tbl[7]  = '{3'd5, 16'h0001, 16'h0013, 3'd0, 3'd0, 3'd4, 0, 16'd0,    0, 16'h0008};
        tbl[8]  = '{3'd6, 16'h8000, 16'h000F, 3'd0, 3'd0, 3'd4, 0, 16'd0,    0, 16'h0001};
        tbl[9]  = '{3'd0, 16'hFFFF, 16'h0002, 3'd0, 3'd0, 3'd0, 0, 16'd0,    0, 16'h0001};
        tbl[10] = '{3'd1, 16'd3,    16'd5,    3'd0, 3'd0, 3'd1, 0, 16'd0,    2, 16'hFFFE};
        tbl[11] = '{3'd0, 16'h1111, 16'h2222, 3'd3, 3'd3, 3'd3, 0, 16'd9,    0, 16'd18};
        tbl[12] = '{3'd7, 16'h0100, 16'hBEEF, 3'd0, 3'd4, 3'd5, 1, 16'h0100, 0, 16'h0000};

        rst               = 1'b1;
        bus.Busy          = 1'b0;
        bus.Clear_counter = 1'b0;
        bus.Ufop          = 3'd0;
        bus.Vj_reg        = 16'd0;
        bus.Vk_reg        = 16'd0;
        bus.Qj_reg        = 3'd0;
        bus.Qk_reg        = 3'd0;
        bus.R_target      = 3'd0;
        bus.Cdb_valid     = 1'b0;
        bus.Cdb_tag       = 3'd0;
        bus.Cdb_data      = 16'd0;
        bus.Cdb_grant     = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_ready", 32'(bus.Ready), 32'd1);
        check("reset_done", 32'(bus.Done), 32'd0);
        check("reset_req", 32'(bus.Cdb_req), 32'd0);
        check("reset_finished", 32'(bus.Finished), 32'd0);
        check("reset_payload", 32'({bus.Cdb_out_tag, bus.Cdb_out_data, bus.Cdb_out_rd}), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 13; i++)
            run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].qj, tbl[i].qk,
                   tbl[i].rd, tbl[i].snoop_k, tbl[i].sdata, tbl[i].gwait, tbl[i].exp);

        // Busy withdrawn during EXEC: no broadcast, then the unit accepts new work normally.
        @(negedge clk);
        bus.Busy      = 1'b1;
        bus.Ufop      = 3'd7;
        bus.Vj_reg    = 16'd7;
        bus.Vk_reg    = 16'd6;
        bus.Qj_reg    = 3'd0;
        bus.Qk_reg    = 3'd0;
        bus.R_target  = 3'd2;
        bus.Cdb_grant = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus.Busy = 1'b0;
        bad = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (bus.Done || bus.Cdb_req || bus.Finished) bad = 1'b1;
        end
        check("abort_exec_quiet", 32'(bad), 32'd0);
        bus.Cdb_grant = 1'b0;
        run_op("after_abort", 3'd0, 16'd1, 16'd1, 3'd0, 3'd0, 3'd6, 0, 16'd0, 0, 16'd2);

        // Reset while parked in BCAST clears every output on the next edge.
        @(negedge clk);
        bus.Busy      = 1'b1;
        bus.Ufop      = 3'd0;
        bus.Vj_reg    = 16'h0010;
        bus.Vk_reg    = 16'h0020;
        bus.R_target  = 3'd7;
        bus.Cdb_grant = 1'b0;
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!bus.Done && cycles < 20);
        check("rst_reach_bcast", 32'(bus.Done), 32'd1);
        rst      = 1'b1;
        bus.Busy = 1'b0;
        @(negedge clk);
        check("rst_bcast_outputs",
              32'({bus.Done, bus.Cdb_req, bus.Finished, bus.Cdb_out_tag, bus.Cdb_out_data, bus.Cdb_out_rd}), 32'd0);
        check("rst_bcast_ready", 32'(bus.Ready), 32'd1);
        rst = 1'b0;

        // Clear_counter held three cycles in EXEC stalls the MUL at zero; result appears one edge after release.
        @(negedge clk);
        bus.Busy          = 1'b1;
        bus.Ufop          = 3'd7;
        bus.Vj_reg        = 16'd7;
        bus.Vk_reg        = 16'd6;
        bus.R_target      = 3'd1;
        bus.Cdb_grant     = 1'b1;
        bus.Clear_counter = 1'b0;
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
            bus.Clear_counter = (cycles >= 2) && (cycles <= 4);
        end while (!bus.Done && cycles < 50);
        bus.Clear_counter = 1'b0;
        check("clear_latency", 32'(cycles), 32'd6);
        check("clear_data", 32'(bus.Cdb_out_data), 32'd42);
        @(negedge clk);
        check("clear_finished", 32'(bus.Finished), 32'd1);
        bus.Busy      = 1'b0;
        bus.Cdb_grant = 1'b0;
        @(negedge clk);

        // Busy with Clear_counter high in IDLE must not start an instruction.
        bus.Busy          = 1'b1;
        bus.Clear_counter = 1'b1;
        bus.Cdb_grant     = 1'b1;
        bad = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (bus.Done || bus.Cdb_req || bus.Finished) bad = 1'b1;
        end
        check("idle_clear_no_start", 32'(bad), 32'd0);
        bus.Busy          = 1'b0;
        bus.Clear_counter = 1'b0;
        bus.Cdb_grant     = 1'b0;
        @(negedge clk);

        for (int n = 0; n < 30; n++) begin
            op      = 3'($urandom_range(7, 0));
            a       = 16'($urandom);
            b       = 16'($urandom);
            sdata   = 16'($urandom);
            stag    = 3'($urandom_range(7, 2));
            dep_sel = int'($urandom_range(3, 0));
            qj      = (dep_sel == 1 || dep_sel == 3) ? stag : 3'd0;
            qk      = (dep_sel == 2 || dep_sel == 3) ? stag : 3'd0;
            run_op($sformatf("rnd%0d", n), op, a, b, qj, qk, 3'($urandom_range(7, 0)),
                   int'($urandom_range(3, 0)), sdata, int'($urandom_range(3, 0)),
                   ref_alu(op, (qj != 3'd0) ? sdata : a, (qk != 3'd0) ? sdata : b));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
